// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the burst address controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } burst_state_t;

   // Native datapath width of the counter; narrower address users truncate.
   localparam int CNT_DP_W = 16;

endpackage

// File: rtl/counter_with_lat.sv
// Loadable up-counter whose output trails its command inputs by CNT_LAT cycles.
// Latency: a command in cycle t is reflected on dout in cycle t+CNT_LAT.
// Backpressure: none; the caller simply withholds inc/set to hold the value.
module counter_with_lat
   import rf_ctrl_pkg::*;
#(
   parameter int WIDTH   = 13,
   parameter int CNT_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic [CNT_DP_W-1:0] set_val,
   input  logic                set_val_vld,
   input  logic                inc,
   output logic [WIDTH-1:0]    dout
);

   logic [CNT_DP_W-1:0] cnt;

   // Count register: clear beats load, load beats increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (set_val_vld) begin
         cnt <= set_val;
      end else if (inc) begin
         cnt <= cnt + CNT_DP_W'(1);
      end
   end

   generate
      if (CNT_LAT == 1) begin : g_no_dly
         assign dout = cnt[WIDTH-1:0];
      end else begin : g_dly
         logic [WIDTH-1:0] dly [CNT_LAT-1];

         // Extra output stages so dout lands exactly CNT_LAT cycles after a command.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < CNT_LAT - 1; i++) dly[i] <= '0;
            end else begin
               dly[0] <= cnt[WIDTH-1:0];
               for (int i = 1; i < CNT_LAT - 1; i++) dly[i] <= dly[i-1];
            end
         end

         assign dout = dly[CNT_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/addr_burst_ctrl.sv
// Burst address generator: loads base_addr into a latency counter, then steps it burst_len-1 times.
// Latency: first address on addr_out CNT_LAT+1 cycles after start is accepted; then one per cycle.
// Backpressure: addr_rdy low fills a skid FIFO; command issue is credit-gated so nothing is lost.
module addr_burst_ctrl
   import rf_ctrl_pkg::*;
#(
   parameter int WIDTH      = 13,
   parameter int LEN_W      = 13,
   parameter int CNT_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base_addr,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] addr_out,
   output logic             addr_vld,
   output logic             addr_last,
   input  logic             addr_rdy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + CNT_LAT + 1);

   burst_state_t            state;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        issued;
   logic [CNT_LAT-1:0]      vpipe;
   logic [CNT_LAT-1:0]      lpipe;
   logic [WIDTH-1:0]        fifo_addr [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_last;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CW-1:0]           fifo_cnt;
   logic [OW-1:0]           inflight;
   logic [OW-1:0]           occupancy;
   logic                    credit_ok;
   logic                    cmd_set;
   logic                    cmd_inc;
   logic                    cmd_last;
   logic                    push;
   logic                    pop;
   logic [WIDTH-1:0]        cnt_dout;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   counter_with_lat #(
      .WIDTH   (WIDTH),
      .CNT_LAT (CNT_LAT)
   ) u_cnt (
      .clk         (clk),
      .rst_n       (~rst),
      .clear       (abort),
      .set_val     (CNT_DP_W'(base_addr)),
      .set_val_vld (cmd_set),
      .inc         (cmd_inc),
      .dout        (cnt_dout)
   );

   // Commands already issued but not yet written into the FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < CNT_LAT; i++) inflight = inflight + OW'(vpipe[i]);
   end

   // A slot is reserved for every in-flight command, so the FIFO can never overflow.
   assign occupancy = OW'(fifo_cnt) + inflight;
   assign credit_ok = occupancy < OW'(FIFO_DEPTH);

   // Decide this cycle's counter command; abort suppresses everything including a new start.
   always_comb begin
      cmd_set  = 1'b0;
      cmd_inc  = 1'b0;
      cmd_last = 1'b0;
      if (!abort) begin
         case (state)
            IDLE: begin
               if (start && (burst_len != '0) && credit_ok) begin
                  cmd_set  = 1'b1;
                  cmd_last = (burst_len == LEN_W'(1));
               end
            end
            ISSUE: begin
               if (credit_ok && (issued < len_q)) begin
                  cmd_inc  = 1'b1;
                  cmd_last = ((issued + LEN_W'(1)) == len_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign push      = vpipe[CNT_LAT-1];
   assign addr_vld  = (fifo_cnt != '0);
   assign pop       = addr_vld && addr_rdy;
   assign addr_out  = addr_vld ? fifo_addr[rd_ptr] : '0;
   assign addr_last = addr_vld && fifo_last[rd_ptr];
   assign busy      = (state != IDLE);

   // Valid/last pipe aligned to counter latency, feeding the first-word-fall-through FIFO.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         vpipe    <= '0;
         lpipe    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         vpipe[0] <= cmd_set || cmd_inc;
         lpipe[0] <= cmd_last;
         for (int i = 1; i < CNT_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            lpipe[i] <= lpipe[i-1];
         end
         if (push) begin
            fifo_addr[wr_ptr] <= cnt_dout;
            fifo_last[wr_ptr] <= lpipe[CNT_LAT-1];
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + CW'(1);
         end else if (!push && pop) begin
            fifo_cnt <= fifo_cnt - CW'(1);
         end
      end
   end

   // Burst sequencer with registered done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         len_q  <= '0;
         issued <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state  <= IDLE;
            issued <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && (burst_len == '0)) begin
                     done <= 1'b1;
                  end else if (cmd_set) begin
                     len_q  <= burst_len;
                     issued <= LEN_W'(1);
                     state  <= cmd_last ? DRAIN : ISSUE;
                  end
               end
               ISSUE: begin
                  if (cmd_inc) begin
                     issued <= issued + LEN_W'(1);
                     if (cmd_last) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  // The last-flagged entry is the final write, so its pop means pipe and FIFO are empty.
                  if (pop && addr_last) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
